// File: rtl/wishbone_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter family.
// Latency: none (types, constants and a combinational helper function only).
// Backpressure: not applicable.
package wishbone_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // Widest requester vector any arbiter instance may present to rr_next.
    localparam int unsigned MAX_INITIATORS = 16;
    localparam int unsigned PICK_IDX_W     = $clog2(MAX_INITIATORS);

    typedef struct packed {
        logic                  found;
        logic [PICK_IDX_W-1:0] idx;
    } pick_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value max_val itself.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    // First asserted req at or after pointer, wrapping at n (n <= MAX_INITIATORS).
    function automatic pick_t rr_next(input logic [PICK_IDX_W-1:0]     pointer,
                                      input logic [MAX_INITIATORS-1:0] req,
                                      input int unsigned               n);
        pick_t                 res;
        logic [PICK_IDX_W:0]   cand;
        res = '0;
        for (int unsigned k = 0; k < MAX_INITIATORS; k++) begin
            cand = {1'b0, pointer} + (PICK_IDX_W+1)'(k);
            if (cand >= (PICK_IDX_W+1)'(n)) begin
                cand = cand - (PICK_IDX_W+1)'(n);
            end
            if ((k < n) && !res.found && req[cand[PICK_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[PICK_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wishbone_rr_picker.sv
// Rotating-priority encoder: first set req bit at or after pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is present.
module wishbone_rr_picker
    import wishbone_arbiter_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   pointer,
    output logic [IdxW-1:0]   idx,
    output logic              found
);

    logic [MAX_INITIATORS-1:0] req_ext;
    logic [PICK_IDX_W-1:0]     ptr_ext;
    pick_t                     pick;

    assign req_ext = MAX_INITIATORS'(req);
    assign ptr_ext = PICK_IDX_W'(pointer);

    // Search the zero-extended request vector with the shared helper.
    always_comb begin
        pick  = rr_next(ptr_ext, req_ext, NumReq);
        idx   = pick.idx[IdxW-1:0];
        found = pick.found;
    end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone target; grant held for a whole CYC.
// Latency: grant registered, target CYC follows winner 1 cycle after request; data path muxed combinationally.
// Backpressure: non-winners always stalled; winner stalled by target stall or when MaxOutstanding are in flight. Optional watchdog: WB_ARBITER_TIMEOUT_EN.
module wishbone_rr_arbiter
    import wishbone_arbiter_pkg::*;
#(
    parameter  int unsigned NumInitiators  = 4,
    parameter  int unsigned AddressWidth   = 16,
    parameter  int unsigned DataWidth      = 8,
    parameter  int unsigned Granularity    = 8,
    parameter  int unsigned TGDWidth       = 1,
    parameter  int unsigned TGAWidth       = 1,
    parameter  int unsigned TGCWidth       = 1,
    parameter  int unsigned MaxOutstanding = 4,
    parameter  int unsigned TimeoutCycles  = 255,
    localparam int unsigned SelWidth       = DataWidth / Granularity,
    localparam int unsigned IdxW           = idx_width(NumInitiators),
    localparam int unsigned OutW           = cnt_width(MaxOutstanding)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    // initiator side
    input  logic [NumInitiators-1:0]                    init_cyc,
    input  logic [NumInitiators-1:0]                    init_stb,
    input  logic [NumInitiators-1:0]                    init_we,
    input  logic [NumInitiators-1:0]                    init_lock,
    input  logic [NumInitiators-1:0][AddressWidth-1:0]  init_adr,
    input  logic [NumInitiators-1:0][DataWidth-1:0]     init_dat_w,
    input  logic [NumInitiators-1:0][SelWidth-1:0]      init_sel,
    input  logic [NumInitiators-1:0][TGAWidth-1:0]      init_tga,
    input  logic [NumInitiators-1:0][TGCWidth-1:0]      init_tgc,
    input  logic [NumInitiators-1:0][TGDWidth-1:0]      init_tgd_w,
    output logic [NumInitiators-1:0]                    init_ack,
    output logic [NumInitiators-1:0]                    init_err,
    output logic [NumInitiators-1:0]                    init_rty,
    output logic [NumInitiators-1:0]                    init_stall,
    output logic [NumInitiators-1:0][DataWidth-1:0]     init_dat_r,
    output logic [NumInitiators-1:0][TGDWidth-1:0]      init_tgd_r,
    // shared target side
    output logic                                        tgt_cyc,
    output logic                                        tgt_stb,
    output logic                                        tgt_we,
    output logic                                        tgt_lock,
    output logic [AddressWidth-1:0]                     tgt_adr,
    output logic [DataWidth-1:0]                        tgt_dat_w,
    output logic [SelWidth-1:0]                         tgt_sel,
    output logic [TGAWidth-1:0]                         tgt_tga,
    output logic [TGCWidth-1:0]                         tgt_tgc,
    output logic [TGDWidth-1:0]                         tgt_tgd_w,
    input  logic                                        tgt_ack,
    input  logic                                        tgt_err,
    input  logic                                        tgt_rty,
    input  logic                                        tgt_stall,
    input  logic [DataWidth-1:0]                        tgt_dat_r,
    input  logic [TGDWidth-1:0]                         tgt_tgd_r,
    // debug
    output logic [IdxW-1:0]                             grant,
    output logic                                        grant_valid
);

    if (NumInitiators < 2 || NumInitiators > MAX_INITIATORS ||
        MaxOutstanding < 1 || TimeoutCycles < 2) begin : g_bad_cfg
        $error("wishbone_rr_arbiter: illegal parameter set");
    end

    arb_state_t      state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [OutW-1:0] outst_q, outst_d;
    logic [IdxW-1:0] pick_idx;
    logic            pick_found;
    logic            owning, win_cyc, full, term, accept, timeout_hit;

    wishbone_rr_picker #(
        .NumReq  (NumInitiators)
    ) u_picker (
        .req     (init_cyc),
        .pointer (ptr_q),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    // Reset releases the bus in the same cycle it is asserted.
    assign owning  = (state_q == ARB_OWN) && !rst;
    assign win_cyc = init_cyc[grant_q];
    assign full    = (outst_q == OutW'(MaxOutstanding));
    assign term    = tgt_ack | tgt_err | tgt_rty;
    assign accept  = tgt_cyc & tgt_stb & ~tgt_stall;

    assign grant       = grant_q;
    assign grant_valid = owning;

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int unsigned TmoW = cnt_width(TimeoutCycles);
    logic [TmoW-1:0] tmo_q, tmo_d;

    // Watchdog fires on the cycle that would be the TimeoutCycles-th silent cycle.
    assign timeout_hit = owning && win_cyc && (outst_q != '0) && !term &&
                         (tmo_q == TmoW'(TimeoutCycles - 1));

    // Count silent cycles with work in flight; any termination or release restarts it.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q != ARB_OWN || !win_cyc || timeout_hit || term) begin
            tmo_d = '0;
        end else if (outst_q != '0) begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Mux the winner onto the target and route responses back only to it.
    always_comb begin
        tgt_cyc    = owning & win_cyc & ~timeout_hit;
        tgt_stb    = tgt_cyc & init_stb[grant_q] & ~full;
        tgt_we     = init_we[grant_q];
        tgt_lock   = tgt_cyc & init_lock[grant_q];
        tgt_adr    = init_adr[grant_q];
        tgt_dat_w  = init_dat_w[grant_q];
        tgt_sel    = init_sel[grant_q];
        tgt_tga    = init_tga[grant_q];
        tgt_tgc    = init_tgc[grant_q];
        tgt_tgd_w  = init_tgd_w[grant_q];
        init_stall = '1;
        init_ack   = '0;
        init_err   = '0;
        init_rty   = '0;
        init_dat_r = '0;
        init_tgd_r = '0;
        if (tgt_cyc) begin
            init_stall[grant_q] = tgt_stall | full;
            init_ack[grant_q]   = tgt_ack;
            init_err[grant_q]   = tgt_err;
            init_rty[grant_q]   = tgt_rty;
            init_dat_r[grant_q] = tgt_dat_r;
            init_tgd_r[grant_q] = tgt_tgd_r;
        end
        if (timeout_hit) begin
            init_err[grant_q] = 1'b1;
        end
    end

    // Ownership FSM and outstanding-request bookkeeping.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        outst_d = outst_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_OWN;
                    grant_d = pick_idx;
                end
            end
            ARB_OWN: begin
                if (!win_cyc || timeout_hit) begin
                    // Late terminations are dropped: the count restarts from zero.
                    state_d = ARB_IDLE;
                    outst_d = '0;
                    ptr_d   = (grant_q == IdxW'(NumInitiators - 1)) ? '0 : grant_q + IdxW'(1);
                end else if (accept && !term) begin
                    outst_d = outst_q + OutW'(1);
                end else if (!accept && term && outst_q != '0) begin
                    outst_d = outst_q - OutW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            outst_q <= outst_d;
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed bench for wishbone_rr_arbiter with a cycle-level behavioural model.
// Latency: model stepped once per clock on the falling edge.
// Backpressure: target stall/ack driven directly by the stimulus sequence.
module tb_wishbone_rr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int SW   = 1;
    localparam int MAXO = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]          init_cyc, init_stb, init_we, init_lock;
    logic [N-1:0][AW-1:0]  init_adr;
    logic [N-1:0][DW-1:0]  init_dat_w;
    logic [N-1:0][SW-1:0]  init_sel;
    logic [N-1:0][0:0]     init_tga, init_tgc, init_tgd_w;
    logic [N-1:0]          init_ack, init_err, init_rty, init_stall;
    logic [N-1:0][DW-1:0]  init_dat_r;
    logic [N-1:0][0:0]     init_tgd_r;
    logic                  tgt_cyc, tgt_stb, tgt_we, tgt_lock;
    logic [AW-1:0]         tgt_adr;
    logic [DW-1:0]         tgt_dat_w;
    logic [SW-1:0]         tgt_sel;
    logic [0:0]            tgt_tga, tgt_tgc, tgt_tgd_w;
    logic                  tgt_ack, tgt_err, tgt_rty, tgt_stall;
    logic [DW-1:0]         tgt_dat_r;
    logic [0:0]            tgt_tgd_r;
    logic [1:0]            grant;
    logic                  grant_valid;

    wishbone_rr_arbiter #(
        .NumInitiators (N), .AddressWidth (AW), .DataWidth (DW), .Granularity (8),
        .TGDWidth (1), .TGAWidth (1), .TGCWidth (1),
        .MaxOutstanding (MAXO), .TimeoutCycles (TMO)
    ) dut (
        .clk (clk), .rst (rst),
        .init_cyc (init_cyc), .init_stb (init_stb), .init_we (init_we), .init_lock (init_lock),
        .init_adr (init_adr), .init_dat_w (init_dat_w), .init_sel (init_sel),
        .init_tga (init_tga), .init_tgc (init_tgc), .init_tgd_w (init_tgd_w),
        .init_ack (init_ack), .init_err (init_err), .init_rty (init_rty), .init_stall (init_stall),
        .init_dat_r (init_dat_r), .init_tgd_r (init_tgd_r),
        .tgt_cyc (tgt_cyc), .tgt_stb (tgt_stb), .tgt_we (tgt_we), .tgt_lock (tgt_lock),
        .tgt_adr (tgt_adr), .tgt_dat_w (tgt_dat_w), .tgt_sel (tgt_sel),
        .tgt_tga (tgt_tga), .tgt_tgc (tgt_tgc), .tgt_tgd_w (tgt_tgd_w),
        .tgt_ack (tgt_ack), .tgt_err (tgt_err), .tgt_rty (tgt_rty), .tgt_stall (tgt_stall),
        .tgt_dat_r (tgt_dat_r), .tgt_tgd_r (tgt_tgd_r),
        .grant (grant), .grant_valid (grant_valid)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural view: who owns the bus, where the rotation resumes, how much is in flight.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_out   = 0;
    int m_timer = 0;
    int acc_cnt = 0;
    int gq[$];
    logic gv_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's outputs from the rules, compare, then advance to the next cycle.
    task automatic model_step();
        bit own, full, term, tmo, acc, e_cyc, e_stb;
        int ow;
        logic [N-1:0]         e_stall, e_ack, e_err, e_rty;
        logic [N-1:0][DW-1:0] e_dat_r;
        own   = (m_owner >= 0) && !rst;
        ow    = own ? m_owner : 0;
        full  = own && (m_out == MAXO);
        term  = tgt_ack || tgt_err || tgt_rty;
        tmo   = 1'b0;
`ifdef WB_ARBITER_TIMEOUT_EN
        tmo   = own && init_cyc[ow] && (m_out > 0) && !term && (m_timer == TMO - 1);
`endif
        e_cyc   = own && init_cyc[ow] && !tmo;
        e_stb   = e_cyc && init_stb[ow] && !full;
        e_dat_r = '0;
        for (int i = 0; i < N; i++) begin
            e_stall[i] = !(e_cyc && i == ow && !tgt_stall && !full);
            e_ack[i]   = e_cyc && i == ow && tgt_ack;
            e_err[i]   = (e_cyc && i == ow && tgt_err) || (tmo && i == ow);
            e_rty[i]   = e_cyc && i == ow && tgt_rty;
        end
        if (e_cyc) e_dat_r[ow] = tgt_dat_r;

        check("m_grant_valid", grant_valid, own);
        if (own) check("m_grant", grant, ow);
        check("m_tgt_cyc", tgt_cyc, e_cyc);
        check("m_tgt_stb", tgt_stb, e_stb);
        check("m_stall", init_stall, e_stall);
        check("m_ack", init_ack, e_ack);
        check("m_err", init_err, e_err);
        check("m_rty", init_rty, e_rty);
        check("m_dat_r", init_dat_r, e_dat_r);
        if (e_cyc) begin
            check("m_tgt_adr", tgt_adr, init_adr[ow]);
            check("m_tgt_dat_w", tgt_dat_w, init_dat_w[ow]);
        end

        if (tgt_cyc && tgt_stb && !tgt_stall) acc_cnt++;
        if (grant_valid && !gv_prev) gq.push_back(int'(grant));
        gv_prev = grant_valid;

        acc = e_stb && !tgt_stall;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_out = 0; m_timer = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && init_cyc[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
        end else if (!init_cyc[m_owner] || tmo) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_out = 0; m_timer = 0;
        end else begin
            if (term) m_timer = 0;
            else if (m_out > 0) m_timer++;
            m_out = m_out + (acc ? 1 : 0) - (term ? 1 : 0);
            if (m_out < 0) m_out = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string nm);
        int n = 0;
        while (!grant_valid && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_grant_wait"}, grant_valid, 1'b1);
    endtask

    initial begin
        int order [4] = '{0, 1, 2, 0};
        int base, g0, n;
        for (int i = 0; i < N; i++) begin
            init_adr[i]   = AW'(16'h1000 + i * 16'h0111);
            init_dat_w[i] = DW'(8'h10 + i);
        end
        init_sel = '1; init_tga = '0; init_tgc = '0; init_tgd_w = '0;
        init_we = '0; init_lock = '0; init_stb = '0;
        tgt_ack = 0; tgt_err = 0; tgt_rty = 0; tgt_stall = 0; tgt_dat_r = '0; tgt_tgd_r = '0;

        // Reset held with every initiator requesting.
        rst = 1'b1; init_cyc = '1;
        repeat (3) tick();
        check("rst_gv", grant_valid, 1'b0);
        check("rst_tgt_cyc", tgt_cyc, 1'b0);
        check("rst_stall", init_stall, 4'hF);
        rst = 1'b0; init_cyc = 4'b0111;
        #1;
        check("post_rst_idle_gv", grant_valid, 1'b0);
        check("post_rst_idle_cyc", tgt_cyc, 1'b0);

        // Fairness: one request per ownership, each owner drops CYC then re-requests.
        g0 = gq.size();
        for (int r = 0; r < 4; r++) begin
            wait_grant("fair");
            check("fair_grant", grant, order[r]);
            init_stb[order[r]] = 1'b1; tick();
            init_stb[order[r]] = 1'b0; tgt_ack = 1'b1; tick();
            tgt_ack = 1'b0; init_cyc[order[r]] = 1'b0; tick();
            if (r < 3) init_cyc[order[r]] = 1'b1;
            else init_cyc = '0;
            check("fair_gap_cyc", tgt_cyc, 1'b0);
            check("fair_gap_gv", grant_valid, 1'b0);
        end
        tick();
        check("fair_log_len", gq.size() - g0, 4);
        for (int r = 0; r < 4; r++) check("fair_log", gq[g0 + r], order[r]);

        // Backpressure: target never acks, winner keeps strobing.
        init_cyc[3] = 1'b1;
        wait_grant("bp");
        check("bp_grant", grant, 2'd3);
        base = acc_cnt; init_stb[3] = 1'b1;
        repeat (6) tick();
        check("bp_accepts", acc_cnt - base, 4);
        check("bp_stall", init_stall[3], 1'b1);
        tgt_ack = 1'b1; tick();
        tgt_ack = 1'b0; tick(); tick();
        check("bp_one_more", acc_cnt - base, 5);
        check("bp_stall_again", init_stall[3], 1'b1);

        // Drain to 2, then accept and ack together: count must stay at 2.
        init_stb[3] = 1'b0; tgt_ack = 1'b1; tick(); tick();
        base = acc_cnt; init_stb[3] = 1'b1; tick();
        tgt_ack = 1'b0; repeat (3) tick();
        check("simul_accepts", acc_cnt - base, 3);
        check("simul_stall", init_stall[3], 1'b1);
        init_stb[3] = 1'b0; tgt_ack = 1'b1; tick();
        tgt_ack = 1'b0; init_cyc[3] = 1'b0; #1;
        check("drop_cyc_now", tgt_cyc, 1'b0);
        tick();
        tgt_ack = 1'b1; #1;
        check("late_ack_gv", grant_valid, 1'b0);
        check("late_ack_hidden", init_ack, 4'h0);
        tick(); tgt_ack = 1'b0;

        // Isolation: initiator 1 owns while 0 and 2 wait.
        init_cyc[1] = 1'b1;
        wait_grant("iso");
        check("iso_grant", grant, 2'd1);
        init_cyc[0] = 1'b1; init_cyc[2] = 1'b1;
        init_stb[1] = 1'b1; tick();
        init_stb[1] = 1'b0; tgt_ack = 1'b1; tgt_dat_r = 8'hA5; #1;
        check("iso_ack", init_ack, 4'b0010);
        check("iso_dat", init_dat_r, 32'h0000_A500);
        check("iso_stall", init_stall & 4'b1101, 4'b1101);
        tick();
        tgt_ack = 1'b0; tgt_err = 1'b1; #1;
        check("iso_err", init_err, 4'b0010);
        tick(); tgt_err = 1'b0;
        base = acc_cnt; init_stb[1] = 1'b1;
        repeat (5) tick();
        check("sat_accepts", acc_cnt - base, 4);
        init_stb[1] = 1'b0; init_cyc[1] = 1'b0; tick();
        check("iso_gap_gv", grant_valid, 1'b0);
        tick();
        check("iso_next_gv", grant_valid, 1'b1);
        check("iso_next_grant", grant, 2'd2);

        // Hung target: one request, never terminated.
        init_stb[2] = 1'b1; tick();
        init_stb[2] = 1'b0;
`ifdef WB_ARBITER_TIMEOUT_EN
        n = 0;
        while (!init_err[2] && n < 30) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 7);
        check("tmo_tgt_cyc", tgt_cyc, 1'b0);
        tick();
        check("tmo_gap_gv", grant_valid, 1'b0);
        tick();
        check("tmo_next_grant", grant, 2'd0);
`else
        n = 0;
        repeat (1000) tick();
        check("hang_gv", grant_valid, 1'b1);
        check("hang_grant", grant, 2'd2);
        check("hang_cyc", tgt_cyc, 1'b1);
        check("hang_n", n, 0);
`endif
        init_cyc = '0; init_stb = '0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
